updown_counter_param: RTL
=========================

Name: updown_counter_param

Overview:
- Parametrised successor to the team's fixed 3-bit loadable down counter.
- Generalised to WIDTH bits with a programmable top value (modulus MAX_VAL+1), a run-time up/down direction, a count enable, a terminal-count flag and a registered wrap pulse.
- Used as a generic event counter, timer prescaler or decade counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits (≥1).
- MAX_VAL, 9, highest count value; the count sequence is 0..MAX_VAL. Must satisfy MAX_VAL ≤ 2**WIDTH-1.
- RST_VAL, 0, value of q_out after reset. Must satisfy RST_VAL ≤ MAX_VAL.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- en, input, 1, count enable; the counter steps once per clock while high.
- load_en, input, 1, synchronous parallel load.
- data_in, input, WIDTH, load value.
- up_dn, input, 1, direction: 1 counts up, 0 counts down.
- q_out, output, WIDTH, registered count.
- tc, output, 1, terminal count (combinational from q_out and up_dn).
- wrap, output, 1, registered one-cycle pulse on wrap-around.

Behaviour:
- One clock domain; all state updates on the rising edge of clk.
- Reset is synchronous active-high, sampled on the clk rising edge.
- Priority per edge: reset > load_en > en > hold.
- Reset: q_out <= RST_VAL, wrap <= 0. Reset held across multiple edges keeps these values. Asserting reset mid-count discards the count on that edge.
- Load: q_out <= data_in, or MAX_VAL if data_in > MAX_VAL (clamp). wrap <= 0. The load wins over en on the same edge, and no count step occurs.
- Count, up (en=1, up_dn=1):
  - q_out < MAX_VAL -> q_out+1, wrap <= 0.
  - q_out == MAX_VAL -> 0, wrap <= 1.
- Count, down (en=1, up_dn=0):
  - q_out > 0 -> q_out-1, wrap <= 0.
  - q_out == 0 -> MAX_VAL, wrap <= 1.
- Hold (en=0, load_en=0): q_out unchanged, wrap <= 0.
- wrap latency: high for exactly the one cycle following the edge that performed the wrap. Continuous counting at modulus N gives a wrap pulse every N cycles.
- tc = (up_dn & q_out==MAX_VAL) | (~up_dn & q_out==0). It is independent of en, and a change of up_dn changes tc in the same cycle.
- A direction change takes effect on the next enabled edge, with no dead cycle.
- Arithmetic is modulo MAX_VAL+1, never modulo 2**WIDTH. Values above MAX_VAL are unreachable after reset or load.
- MAX_VAL == 2**WIDTH-1 must behave identically to a natural binary wrap.
- No output is X after the first reset edge.

Optional Feature:
- Macro: UPDOWN_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Counting up at MAX_VAL holds at MAX_VAL; counting down at 0 holds at 0.
  - wrap is tied to 0.
  - tc still asserts at the boundary, indicating saturation.
- Undefined (default): the wrap-around behaviour described above.
- The port list is identical in both builds.

Test Plan:
1. Reset and up count (WIDTH=4, MAX_VAL=9): reset=1 for 2 edges -> q_out=0, wrap=0. Then en=1, up_dn=1 for 12 edges -> q_out 1..9,0,1,2. tc=1 while q_out=9. wrap=1 for exactly the cycle after 9->0.
2. Down wrap: load data_in=2, then en=1, up_dn=0 -> q_out 2,1,0,9,8. tc=1 at q_out=0. wrap pulses once after 0->9.
3. Load priority and clamp:
   - load_en=1, en=1, data_in=5 -> q_out=5, with no step on that edge.
   - data_in=13 -> q_out=9.
4. Hold and direction change:
   - en=0 for 5 edges at q_out=4 -> stays 4, wrap=0.
   - Toggle up_dn at q_out=0 -> tc follows the same cycle (1 when down, 0 when up).
5. Reset mid-operation: counting up at q_out=7, with reset=1 and load_en=1 on the same edge -> q_out=RST_VAL(0), wrap=0. Counting resumes from 0 after release.
6. UPDOWN_COUNTER_SAT_EN build: count up from 8 for 4 edges -> 9,9,9,9 with wrap=0 and tc=1. Count down from 1 -> 0,0 with tc=1.

Source files
------------

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised loadable up/down modulo counter
//
// Purpose:
//   Counts 0..MAX_VAL (modulus MAX_VAL+1) in either direction.
//   A synchronous load clamps its value to MAX_VAL.
//   It drives a combinational terminal-count flag and a registered one-cycle wrap pulse.
//   Per-edge priority: reset > load_en > en > hold.
//
// Optional build macro:
//   UPDOWN_COUNTER_SAT_EN - when defined, the count saturates at the ends
//   instead of wrapping, and wrap stays 0. The port list does not change.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (q_out <= RST_VAL, wrap <= 0)
//   en       in   count enable, one step per clock while high
//   load_en  in   synchronous parallel load of data_in (clamped to MAX_VAL)
//   data_in  in   [WIDTH-1:0] load value
//   up_dn    in   direction, 1 = up, 0 = down
//   q_out    out  [WIDTH-1:0] registered count
//   tc       out  terminal count for the current direction (combinational)
//   wrap     out  registered pulse, high the cycle after a wrap-around edge

module updown_counter_param #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;

  assign at_max  = (q_q == MAX_V);
  assign at_zero = (q_q == ZERO_V);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load_en) begin
      // Clamp out-of-range loads so values above MAX_VAL stay unreachable.
      q_d = (data_in > MAX_V) ? MAX_V : data_in;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          q_d    = MAX_V;
`else
          q_d    = ZERO_V;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q + ONE_V;
        end
      end else begin
        if (at_zero) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          q_d    = ZERO_V;
`else
          q_d    = MAX_V;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q - ONE_V;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= RST_V;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q_out = q_q;
  assign wrap  = wrap_q;
  // tc follows up_dn immediately, independent of en.
  assign tc    = (up_dn & at_max) | (~up_dn & at_zero);

endmodule
